aead_serial_host: RTL and testbench
===================================

Name: aead_serial_host

Overview:
- Host-side driver for the bit-serial AEAD decryption link.
- Takes a parallel key/nonce/AD/ciphertext job, resets the serial device, and shifts the fields out MSB-first on four serial lines.
- Raises decryption-start once the device's input frame is complete, then deserializes the LSB-first plaintext and tag streams back into parallel registers.
- Sits between the on-chip request logic and the serial decryption device.

Parameters:
- K, 128, key width in bits.
- L, 40, associated-data width in bits.
- Y, 40, ciphertext/plaintext width in bits.
- TIMEOUT, 1024, maximum cycles in WAIT_READY before abort.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start_i  in  1  job request, sampled only in IDLE
- key_i  in  K  key
- nonce_i  in  128  nonce
- ad_i  in  L  associated data
- ct_i  in  Y  ciphertext
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle completion pulse
- timeout_o  out  1  one-cycle pulse, coincident with done_o on abort
- pt_o  out  Y  recovered plaintext
- tag_o  out  128  recovered tag
- link_rst_o  out  1  active-low reset to the serial device
- key_so, nonce_so, ad_so, ct_so  out  1 each  serial field bits
- dec_start_so  out  1  decryption start to the device
- pt_si, tag_si  in  1 each  serial plaintext/tag bits
- dec_ready_si  in  1  device decryption-ready

Behaviour:
- Reset values:
  - All outputs are 0, including link_rst_o = 0, which holds the device in reset.
  - FSM returns to IDLE.
  - Reset mid-operation aborts the job with no done_o and no timeout_o.
- Link outputs are registered.
- N = max(K, 128, L, Y); M = max(Y, 128).
- IDLE:
  - link_rst_o = 1.
  - On start_i: latch all four fields into shift registers, clear the bit counter, go to LINK_RST.
  - start_i outside IDLE is ignored.
- LINK_RST: 2 cycles with link_rst_o = 0, then SHIFT.
- SHIFT: N cycles, link_rst_o = 1.
  - In cycle c each line carries field[W-1-c] while c < W, else 0.
  - The first SHIFT cycle carries bit index 0, on the same edge that link_rst_o rises.
- PAD: 1 cycle with all lines 0, so the device's input counter reaches N+1 and it is ready.
- WAIT_READY:
  - dec_start_so = 1; it rises exactly 2+N+1 cycles after the start_i accept edge.
  - Sampling dec_ready_si = 1 enters COLLECT and clears dec_start_so.
  - After TIMEOUT cycles without ready: pulse timeout_o and done_o, drive link_rst_o = 0 for one cycle, then IDLE. pt_o/tag_o are unchanged on abort.
- COLLECT:
  - The device registers its outputs, so bit j is valid in the cycle after the j-th edge on which dec_ready_si was high.
  - Host keeps a 1-cycle delayed copy of ready; when that copy is 1, sample pt_si into pt_o[j] (if j < Y) and tag_si into tag_o[j] (if j < 128), then increment j.
  - While ready is low, no sample is taken and j holds; the stream resumes when ready returns.
  - After M samples: pulse done_o, go to IDLE.
- pt_o/tag_o hold their values until overwritten by the next job's COLLECT.
- Width rules:
  - Counters are clog2(max(N+1, M, TIMEOUT)+1) bits wide.
  - No counter wraps within a job.

Decomposition:
- Shared package aead_serial_pkg holds:
  - FSM state enum: IDLE, LINK_RST, SHIFT, PAD, WAIT_READY, COLLECT.
  - NONCE_W = 128 and TAG_W = 128.
  - A max helper function.
- One sub-module, aead_piso_bank: four parallel-load, MSB-first shift registers with per-field width gating.

Test Plan:
- Frame check (K=128, L=40, Y=40):
  - Stimulus: key=128'h000102030405060708090A0B0C0D0E0F, ad=40'h0102030405, ct=40'hA5A50F0F33.
  - key_so emits 0x00 bits first; ad_so and ct_so go 0 after 40 SHIFT cycles.
  - dec_start_so rises 131 cycles after accept.
- Collection:
  - Stimulus: device model raises ready 5 cycles after start, streams pt=40'h1122334455 and tag=128'hDEADBEEF00000000CAFEBABE12345678 LSB-first.
  - done_o pulses once after 128 samples; pt_o and tag_o match exactly.
- Ready gap:
  - Stimulus: drop dec_ready_si for 3 cycles at bit 60.
  - No samples taken during the gap; final tag_o is still correct; done_o is delayed by 3 cycles.
- Timeout:
  - Stimulus: ready never asserted.
  - Exactly TIMEOUT cycles after dec_start_so rises: timeout_o and done_o pulse, link_rst_o goes low for one cycle, pt_o is unchanged.
- Reset and ignored start:
  - Asserting rst at SHIFT cycle 50 sets all outputs to 0 and returns to IDLE with no done_o.
  - start_i pulsed while busy_o = 1 does not restart the job.

Source files
------------

// File: rtl/aead_serial_pkg.sv
// Shared state encoding and constants for the bit-serial AEAD host driver.
package aead_serial_pkg;

  localparam int NONCE_W = 128;
  localparam int TAG_W   = 128;

  typedef enum logic [2:0] {
    IDLE,
    LINK_RST,
    SHIFT,
    PAD,
    WAIT_READY,
    COLLECT
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aead_piso_bank.sv
// Four parallel-load, MSB-first shift registers feeding registered serial lines.
module aead_piso_bank
  import aead_serial_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [K-1:0]       key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [L-1:0]       ad,
  input  logic [Y-1:0]       ct,
  output logic               key_so,
  output logic               nonce_so,
  output logic               ad_so,
  output logic               ct_so
);

  logic [K-1:0]       key_sr;
  logic [NONCE_W-1:0] nonce_sr;
  logic [L-1:0]       ad_sr;
  logic [Y-1:0]       ct_sr;

  // Zero-fill on shift, so a field shorter than the frame drains to 0 by itself.
  always_ff @(posedge clk) begin
    if (load) begin
      key_sr   <= key;
      nonce_sr <= nonce;
      ad_sr    <= ad;
      ct_sr    <= ct;
    end else if (shift) begin
      key_sr   <= key_sr << 1;
      nonce_sr <= nonce_sr << 1;
      ad_sr    <= ad_sr << 1;
      ct_sr    <= ct_sr << 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_so   <= 1'b0;
      nonce_so <= 1'b0;
      ad_so    <= 1'b0;
      ct_so    <= 1'b0;
    end else begin
      key_so   <= shift & key_sr[K-1];
      nonce_so <= shift & nonce_sr[NONCE_W-1];
      ad_so    <= shift & ad_sr[L-1];
      ct_so    <= shift & ct_sr[Y-1];
    end
  end

endmodule

// File: rtl/aead_serial_host.sv
// Host driver: resets the serial AEAD device, shifts a job out, then gathers plaintext and tag.
module aead_serial_host
  import aead_serial_pkg::*;
#(
  parameter int K       = 128,
  parameter int L       = 40,
  parameter int Y       = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [K-1:0]       key_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic [L-1:0]       ad_i,
  input  logic [Y-1:0]       ct_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [Y-1:0]       pt_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               link_rst_o,
  output logic               key_so,
  output logic               nonce_so,
  output logic               ad_so,
  output logic               ct_so,
  output logic               dec_start_so,
  input  logic               pt_si,
  input  logic               tag_si,
  input  logic               dec_ready_si
);

  localparam int N  = max2(max2(K, NONCE_W), max2(L, Y));
  localparam int M  = max2(Y, TAG_W);
  localparam int CW = $clog2(max2(max2(N + 1, M), TIMEOUT) + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] M_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_p1;
  logic             link_rst_d, dec_start_d, done_d, timeout_d;
  logic [Y-1:0]     pt_d;
  logic [TAG_W-1:0] tag_d;
  logic             load, shift;

  assign busy_o = (state_q != IDLE);

  aead_piso_bank #(.K(K), .L(L), .Y(Y)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .key      (key_i),
    .nonce    (nonce_i),
    .ad       (ad_i),
    .ct       (ct_i),
    .key_so   (key_so),
    .nonce_so (nonce_so),
    .ad_so    (ad_so),
    .ct_so    (ct_so)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    link_rst_d  = 1'b1;
    dec_start_d = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    pt_d        = pt_o;
    tag_d       = tag_o;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          cnt_d      = '0;
          link_rst_d = 1'b0;
          state_d    = LINK_RST;
        end
      end
      LINK_RST: begin
        link_rst_d = 1'b0;
        cnt_d      = cnt_q + CNT_ONE;
        // Leaving reset: the first frame bit goes out on the same edge link_rst_o rises.
        if (cnt_q == CNT_ONE) begin
          link_rst_d = 1'b1;
          shift      = 1'b1;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = PAD;
        end else begin
          shift = 1'b1;
        end
      end
      PAD: begin
        dec_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT_READY;
      end
      WAIT_READY: begin
        dec_start_d = 1'b1;
        cnt_d       = cnt_q + CNT_ONE;
        if (dec_ready_si) begin
          dec_start_d = 1'b0;
          cnt_d       = '0;
          state_d     = COLLECT;
        end else if (cnt_q == TO_LAST) begin
          dec_start_d = 1'b0;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          link_rst_d  = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      COLLECT: begin
        // Device outputs lag its ready by one edge, so sample on the delayed copy.
        if (ready_p1) begin
          for (int i = 0; i < Y; i++) begin
            if (cnt_q == CW'(i)) pt_d[i] = pt_si;
          end
          for (int i = 0; i < TAG_W; i++) begin
            if (cnt_q == CW'(i)) tag_d[i] = tag_si;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == M_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_p1     <= 1'b0;
      link_rst_o   <= 1'b0;
      dec_start_so <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      pt_o         <= '0;
      tag_o        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_p1     <= dec_ready_si;
      link_rst_o   <= link_rst_d;
      dec_start_so <= dec_start_d;
      done_o       <= done_d;
      timeout_o    <= timeout_d;
      pt_o         <= pt_d;
      tag_o        <= tag_d;
    end
  end

endmodule

// File: tb/tb_aead_serial_host.sv
// Randomised bench for aead_serial_host with a serial-device model and a done_o scoreboard.
module tb_aead_serial_host;

  localparam int K       = 128;
  localparam int L       = 40;
  localparam int Y       = 40;
  localparam int TIMEOUT = 1024;
  localparam int N       = 128;
  localparam int FRAME_K = 2 + N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic [K-1:0]   key_i = '0;
  logic [127:0]   nonce_i = '0;
  logic [L-1:0]   ad_i = '0;
  logic [Y-1:0]   ct_i = '0;
  logic           busy_o, done_o, timeout_o;
  logic [Y-1:0]   pt_o;
  logic [127:0]   tag_o;
  logic           link_rst_o, key_so, nonce_so, ad_so, ct_so, dec_start_so;
  logic           pt_si = 1'b0;
  logic           tag_si = 1'b0;
  logic           dec_ready_si = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit           to;
    logic [Y-1:0] pt;
    logic [127:0] tag;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [Y-1:0] model_pt = '0;
  logic [127:0] model_tag = '0;

  always #5 clk = ~clk;

  aead_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .key_i        (key_i),
    .nonce_i      (nonce_i),
    .ad_i         (ad_i),
    .ct_i         (ct_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .pt_o         (pt_o),
    .tag_o        (tag_o),
    .link_rst_o   (link_rst_o),
    .key_so       (key_so),
    .nonce_so     (nonce_so),
    .ad_so        (ad_so),
    .ct_so        (ct_so),
    .dec_start_so (dec_start_so),
    .pt_si        (pt_si),
    .tag_si       (tag_si),
    .dec_ready_si (dec_ready_si)
  );

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  // Scoreboard monitor: every done_o pulse consumes one expected job result.
  always @(negedge clk) begin
    if (rst === 1'b1 && done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done_o=1 required no pending job");
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_timeout", timeout_o, mon_e.to);
        chk("sb_pt", pt_o, mon_e.pt);
        chk("sb_tag", tag_o, mon_e.tag);
      end
    end
  end

  task automatic run_job(input logic [K-1:0] key, input logic [127:0] nonce,
                         input logic [L-1:0] ad, input logic [Y-1:0] ct,
                         input logic [Y-1:0] pt_dev, input logic [127:0] tag_dev,
                         input bit never_ready, input int d_rdy, input int gap_at,
                         input int gap_len, input bit poke);
    logic [127:0] cap_key, cap_nonce, cap_ad, cap_ct;
    logic [63:0]  r;
    int           k, c, e, ctrl_bad, done_k, done_cnt, rise_k, j, gap_used, exp_done_k;
    bit           rdy, finished;
    exp_t         x;
    cap_key = '0; cap_nonce = '0; cap_ad = '0; cap_ct = '0;
    ctrl_bad = 0; done_k = -1; done_cnt = 0; rise_k = -1; j = 0; gap_used = 0;
    rdy = 1'b0; finished = 1'b0;
    x.to = never_ready;
    if (never_ready) begin
      x.pt = model_pt; x.tag = model_tag;
    end else begin
      x.pt = pt_dev; x.tag = tag_dev;
      model_pt = pt_dev; model_tag = tag_dev;
    end
    exp_done_k = never_ready ? FRAME_K + TIMEOUT : d_rdy + 129 + gap_len;

    @(posedge clk); #1;
    key_i = key; nonce_i = nonce; ad_i = ad; ct_i = ct;
    dec_ready_si = 1'b0;
    start_i = 1'b1;
    sb_q.push_back(x);
    @(posedge clk); #1;
    start_i = 1'b0;

    k = 0;
    while (k <= 3000 && !finished) begin
      @(negedge clk);
      if (k == 0) chk("busy_accept", busy_o, 1'b1);
      if (k <= 1) ctrl_bad += (link_rst_o !== 1'b0);
      if (k >= 2 && k <= N + 1) begin
        c = k - 2;
        cap_key[127-c] = key_so; cap_nonce[127-c] = nonce_so;
        cap_ad[127-c] = ad_so;   cap_ct[127-c] = ct_so;
        ctrl_bad += (link_rst_o !== 1'b1);
      end
      if (k == N + 2) ctrl_bad += ({key_so, nonce_so, ad_so, ct_so} !== 4'b0);
      if (k < FRAME_K) ctrl_bad += (dec_start_so !== 1'b0);
      else if (rise_k < 0 && dec_start_so === 1'b1) rise_k = k;
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          chk("done_link_rst", link_rst_o, !never_ready);
          chk("done_dec_start", dec_start_so, 1'b0);
        end
      end
      if (done_k >= 0 && k == done_k + 1) begin
        chk("post_busy", busy_o, 1'b0);
        chk("post_link_rst", link_rst_o, 1'b1);
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        e = k + 1;
        // Device model: a ready edge makes the next LSB-first bit appear after it.
        if (rdy) begin
          r = {$urandom, $urandom};
          pt_si  = (j < Y)   ? pt_dev[j]  : r[0];
          tag_si = (j < 128) ? tag_dev[j] : r[1];
          j++;
        end
        rdy = !never_ready && (e >= d_rdy) && (done_k < 0);
        if (rdy && j == gap_at && gap_used < gap_len) begin
          rdy = 1'b0;
          gap_used++;
        end
        dec_ready_si = rdy;
        start_i = poke && (e == 20 || e == 135);
        if (start_i) key_i = {$urandom, $urandom, $urandom, $urandom};
        k++;
      end
    end
    dec_ready_si = 1'b0;
    start_i = 1'b0;
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL job_watchdog: got no done_o within %0d cycles required done at %0d", k, exp_done_k);
    end
    chk("frame_key", cap_key, key);
    chk("frame_nonce", cap_nonce, nonce);
    chk("frame_ad", cap_ad, {ad, 88'b0});
    chk("frame_ct", cap_ct, {ct, 88'b0});
    chk("frame_ctrl_errs", ctrl_bad, 0);
    chk("dec_start_rise", rise_k, FRAME_K);
    chk("done_cycle", done_k, exp_done_k);
    chk("done_pulses", done_cnt, 1);
  endtask

  task automatic run_random_job();
    logic [63:0]  r1, r2;
    logic [127:0] kk, nn, tg;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    kk = {$urandom, $urandom, $urandom, $urandom};
    nn = {$urandom, $urandom, $urandom, $urandom};
    tg = {$urandom, $urandom, $urandom, $urandom};
    run_job(kk, nn, r1[39:0], r2[39:0], r1[63:24], tg, 1'b0,
            FRAME_K + int'($urandom_range(0, 8)), int'($urandom_range(1, 120)),
            int'($urandom_range(0, 4)), 1'b0);
  endtask

  initial begin
    logic [127:0] fkey, rn1, rn2;
    logic [63:0]  r;
    fkey = 128'h000102030405060708090A0B0C0D0E0F;
    rn1 = {$urandom, $urandom, $urandom, $urandom};
    rn2 = {$urandom, $urandom, $urandom, $urandom};

    #2 rst = 1'b0;
    #20;
    chk("reset_ctrl", {busy_o, done_o, timeout_o, link_rst_o, dec_start_so,
                       key_so, nonce_so, ad_so, ct_so}, 9'b0);
    chk("reset_pt", pt_o, '0);
    chk("reset_tag", tag_o, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_link_rst", link_rst_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);

    // Frame and collection, with start pokes that must be ignored.
    run_job(fkey, rn1, 40'h0102030405, 40'hA5A50F0F33, 40'h1122334455,
            128'hDEADBEEF00000000CAFEBABE12345678, 1'b0, FRAME_K + 5, 0, 0, 1'b1);
    // Same job with a 3-cycle ready gap at bit 60.
    run_job(fkey, rn1, 40'h0102030405, 40'hA5A50F0F33, 40'h1122334455,
            128'hDEADBEEF00000000CAFEBABE12345678, 1'b0, FRAME_K + 5, 60, 3, 1'b0);
    // Ready never comes: abort, results untouched.
    r = {$urandom, $urandom};
    run_job(rn2, rn1, r[39:0], r[63:24], r[40:1], rn2, 1'b1, 0, 0, 0, 1'b0);

    // Reset in the middle of SHIFT.
    @(posedge clk); #1;
    key_i = rn2; nonce_i = rn1; ad_i = r[39:0]; ct_i = r[63:24];
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (52) @(posedge clk);
    #2;
    chk("shift50_busy", busy_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {busy_o, done_o, timeout_o, link_rst_o, dec_start_so,
                        key_so, nonce_so, ad_so, ct_so}, 9'b0);
    chk("midrst_pt", pt_o, '0);
    chk("midrst_tag", tag_o, '0);
    model_pt = '0;
    model_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_busy", busy_o, 1'b0);
    chk("after_rst_link", link_rst_o, 1'b1);

    for (int n = 0; n < 3; n++) run_random_job();

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
